core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles any memory request may wait for its grant.
REQ-002 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL have ports `clk` (input, 1): single clock; all state changes on its rising edge.
REQ-004 SHALL have port `rst_n` (input, 1): reset, asynchronous, active-low.
REQ-005 SHALL have input port `opcode` (7 bits): opcode from the decoder, valid while the instruction register holds the current instruction.
REQ-006 SHALL have input port `func3` (3 bits): func3 from the decoder.
REQ-007 SHALL have input port `branch_taken` (1 bit): comparator result, valid in EXEC.
REQ-008 SHALL have handshake port pairs:
- `imem_req` (output, 1) / `imem_gnt` (input, 1)
- `dmem_req` (output, 1) / `dmem_gnt` (input, 1)
REQ-009 SHALL have output port `dmem_we` (1 bit): store strobe, qualified by `dmem_req`.
REQ-010 SHALL have output `ir_we` (1 bit): instruction-register load.
REQ-011 SHALL have outputs `pc_we` (1 bit) and `pc_src` (2 bits): 00 pc+4, 01 pc+imm, 10 ALU result.
REQ-012 SHALL have output `RegWrite` (1 bit): register-file write enable.
REQ-013 SHALL have output `wb_sel` (2 bits): 00 ALU, 01 load data, 10 pc+4.
REQ-014 SHALL have status outputs:
- `halted` (1), `illegal` (1), `bus_err` (1)
- `state` (3 bits)
- `instret` (CNT_W bits)

Function
REQ-015 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB, HALT and TRAP.
REQ-016 FETCH SHALL behave as follows:
- `imem_req`=1 every cycle in FETCH.
- On `imem_gnt`=1: `ir_we`=1 in that same cycle (Mealy), then next state DECODE.
REQ-017 DECODE SHALL latch `opcode` and `func3` into internal registers; all later states use only the latched copies.
REQ-018 DECODE transitions SHALL be:
- Legal RV32I opcodes (0000011, 0100011, 0010011, 0110011, 0110111, 0010111, 1101111, 1100111, 1100011) -> EXEC.
- 1110011 with func3=000 -> HALT.
- Anything else -> TRAP with `illegal`=1.
REQ-019 EXEC transitions SHALL be:
- LOAD/STORE -> MEM.
- BRANCH: `pc_we`=1, `pc_src`=01 if `branch_taken` else 00, `instret`+1 -> FETCH.
- All others -> WB.
REQ-020 MEM SHALL behave as follows:
- `dmem_req`=1; `dmem_we`=1 only for STORE.
- On `dmem_gnt`, STORE: `pc_we`=1, `pc_src`=00, `instret`+1 -> FETCH.
- On `dmem_gnt`, LOAD: -> WB.
REQ-021 WB SHALL behave as follows:
- Single cycle: `RegWrite`=1, `pc_we`=1, `instret`+1 -> FETCH.
- `wb_sel`: 01 for LOAD, 10 for JAL/JALR, else 00.
- `pc_src`: 01 for JAL, 10 for JALR, else 00.
REQ-022 Outputs not named for a state SHALL be 0 in that state; `RegWrite`, `pc_we`, `ir_we` and `dmem_we` are never asserted simultaneously with TRAP or HALT.
REQ-023 The wait counter SHALL:
- Clear on entry to FETCH or MEM.
- Increment each cycle the request is high without a grant.
- On reaching TIMEOUT without a grant, force TRAP with `bus_err`=1.
- A grant on the cycle the count equals TIMEOUT SHALL win (normal transition).
REQ-024 HALT and TRAP SHALL be absorbing; only reset exits them. `halted`, `illegal` and `bus_err` SHALL be sticky until reset.
REQ-025 `instret` SHALL wrap modulo 2^CNT_W without a flag.
REQ-026 `state` SHALL encode FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.

Reset
REQ-027 While `rst_n`=0 the block SHALL hold:
- `state`=FETCH.
- All outputs 0, including `imem_req`.
- `instret`=0, wait counter=0, sticky flags=0.
- Latched opcode/func3 = 0.
REQ-028 `imem_req` SHALL rise in the first cycle after `rst_n` deasserts.
REQ-029 Reset asserted mid-transaction SHALL abort immediately; no `RegWrite`, `pc_we` or `instret` update from the aborted instruction.

Structure
REQ-030 Shared package `rv32_pkg` SHALL hold:
- Opcode constants.
- State enum.
- `pc_src` and `wb_sel` encodings.
REQ-031 The wait counter SHALL be sub-module `wait_timer` (inputs clear/count, TIMEOUT parameter, output expired); the FSM and decode of the latched opcode stay in `core_sequencer`.

Verification
REQ-032 The bench SHALL cover ADDI (0010011) with `imem_gnt` on the first cycle -> states 0,1,2,4,0; `RegWrite`=1 and `pc_we`=1 only in WB; `instret` 0->1.
REQ-033 The bench SHALL cover LW with `dmem_gnt` delayed 3 cycles -> `dmem_req` high 4 cycles, `dmem_we`=0; WB has `wb_sel`=01; 7 cycles from fetch grant to next FETCH.
REQ-034 The bench SHALL cover BEQ with `branch_taken`=1 -> `pc_we`=1, `pc_src`=01 in EXEC, no `RegWrite`; with `branch_taken`=0 -> `pc_src`=00.
REQ-035 The bench SHALL cover opcode 0000000 -> TRAP, `illegal`=1, held for 20 cycles; `rst_n` pulse -> FETCH, flags 0.
REQ-036 The bench SHALL cover TIMEOUT=4 with `imem_gnt` never asserted -> TRAP with `bus_err`=1 after 4 waiting cycles; a repeat run with grant on wait cycle 4 -> DECODE.
REQ-037 The bench SHALL cover ECALL (1110011, func3=000) -> HALT, `halted`=1; reset asserted during MEM -> no `instret` increment.

Source files
------------

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared opcodes, state/class enums and mux encodings for the sequencer
package rv32_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_PRIV   = 3'b000;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_HALT,
        CL_ILLEGAL
    } op_class_t;

    // One decode table shared by the DECODE check and the later latched-copy decode.
    function automatic op_class_t classify(input logic [6:0] op, input logic [2:0] f3);
        op_class_t cls;
        case (op)
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_BRANCH: cls = CL_BRANCH;
            OP_JAL:    cls = CL_JAL;
            OP_JALR:   cls = CL_JALR;
            OP_IMM, OP_REG, OP_LUI, OP_AUIPC: cls = CL_ALU;
            OP_SYSTEM: cls = (f3 == F3_PRIV) ? CL_HALT : CL_ILLEGAL;
            default:   cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - saturating grant-wait counter; expired once the count reaches TIMEOUT
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32I control sequencer with grant timeouts and retire counter
module core_sequencer
    import rv32_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_gnt,
    output logic             dmem_req,
    input  logic             dmem_gnt,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             RegWrite,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    state_t     state_q, state_d;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    op_class_t  cls_in, cls_q;

    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c, reg_write_c;
    logic [1:0] pc_src_c, wb_sel_c;
    logic       retire, set_halt, set_ill, set_berr;
    logic       tmr_clear, tmr_count, tmr_expired;

    assign cls_in = classify(opcode, func3);
    assign cls_q  = classify(op_q, f3_q);

    always_comb begin
        state_d     = state_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        pc_src_c    = PC_PLUS4;
        reg_write_c = 1'b0;
        wb_sel_c    = WB_ALU;
        retire      = 1'b0;
        set_halt    = 1'b0;
        set_ill     = 1'b0;
        set_berr    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_gnt) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    set_berr = 1'b1;
                    state_d  = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (cls_in == CL_HALT) begin
                    set_halt = 1'b1;
                    state_d  = ST_HALT;
                end else if (cls_in == CL_ILLEGAL) begin
                    set_ill = 1'b1;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    CL_BRANCH: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = branch_taken ? PC_IMM : PC_PLUS4;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CL_ALU, CL_JAL, CL_JALR: state_d = ST_WB;
                    default: state_d = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls_q == CL_STORE);
                if (dmem_gnt) begin
                    if (cls_q == CL_STORE) begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmr_expired) begin
                    set_berr = 1'b1;
                    state_d  = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_write_c = 1'b1;
                pc_we_c     = 1'b1;
                retire      = 1'b1;
                state_d     = ST_FETCH;
                case (cls_q)
                    CL_LOAD: wb_sel_c = WB_LOAD;
                    CL_JAL:  begin wb_sel_c = WB_PC4; pc_src_c = PC_IMM; end
                    CL_JALR: begin wb_sel_c = WB_PC4; pc_src_c = PC_ALU; end
                    default: wb_sel_c = WB_ALU;
                endcase
            end
            ST_HALT, ST_TRAP: state_d = state_q;
            default: state_d = ST_TRAP;
        endcase
    end

    // Only bus-facing waits count; any move into FETCH or MEM starts a fresh window.
    assign tmr_clear = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));
    assign tmr_count = (imem_req_c && !imem_gnt) || (dmem_req_c && !dmem_gnt);

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .count   (tmr_count),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            f3_q    <= '0;
            instret <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
                f3_q <= func3;
            end
            if (retire) begin
                instret <= instret + 1'b1;
            end
            halted  <= halted  | set_halt;
            illegal <= illegal | set_ill;
            bus_err <= bus_err | set_berr;
        end
    end

    // Strobes are masked by reset so nothing reaches the buses while rst_n is low.
    assign imem_req = rst_n & imem_req_c;
    assign dmem_req = rst_n & dmem_req_c;
    assign dmem_we  = rst_n & dmem_we_c;
    assign ir_we    = rst_n & ir_we_c;
    assign pc_we    = rst_n & pc_we_c;
    assign RegWrite = rst_n & reg_write_c;
    assign pc_src   = rst_n ? pc_src_c : 2'b00;
    assign wb_sel   = rst_n ? wb_sel_c : 2'b00;
    assign state    = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - randomized self-checking bench for core_sequencer against a trace model
module tb_core_sequencer;

    localparam int TMO = 4;
    localparam int CW  = 4;

    localparam logic [6:0] L_LOAD = 7'b0000011, L_STORE = 7'b0100011, L_IMM = 7'b0010011;
    localparam logic [6:0] L_REG = 7'b0110011, L_LUI = 7'b0110111, L_AUIPC = 7'b0010111;
    localparam logic [6:0] L_JAL = 7'b1101111, L_JALR = 7'b1100111, L_BR = 7'b1100011;
    localparam logic [6:0] L_SYS = 7'b1110011;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = '0;
    logic [2:0]    func3 = '0;
    logic          branch_taken = 1'b0, imem_gnt = 1'b0, dmem_gnt = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_write;
    logic [1:0]    pc_src, wb_sel;
    logic          halted, illegal, bus_err;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    core_sequencer #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .branch_taken(branch_taken),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .dmem_req(dmem_req), .dmem_gnt(dmem_gnt),
        .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .RegWrite(reg_write),
        .wb_sel(wb_sel), .halted(halted), .illegal(illegal), .bus_err(bus_err),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic          imem_req, ir_we, dmem_req, dmem_we, pc_we;
        logic [1:0]    pc_src;
        logic          reg_write;
        logic [1:0]    wb_sel;
        logic          halted, illegal, bus_err;
        logic [CW-1:0] instret;
    } out_t;

    typedef struct {
        logic       ig, dg, bt;
        logic [6:0] op;
        logic [2:0] f3;
        out_t       o;
    } rec_t;

    out_t obs;
    assign obs = {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, reg_write, wb_sel,
                  halted, illegal, bus_err, instret};

    rec_t          q[$];
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] m_ret = '0;
    logic          m_halt = 1'b0, m_ill = 1'b0, m_berr = 1'b0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction
    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction
    function automatic logic [2:0] rf();
        return 3'($urandom);
    endfunction

    function automatic out_t base(input logic [2:0] st);
        out_t o = '0;
        o.st = st; o.halted = m_halt; o.illegal = m_ill; o.bus_err = m_berr; o.instret = m_ret;
        return o;
    endfunction

    function automatic void add(input logic ig, input logic dg, input logic bt,
                                input logic [6:0] op, input logic [2:0] f3, input out_t o);
        rec_t r;
        r.ig = ig; r.dg = dg; r.bt = bt; r.op = op; r.f3 = f3; r.o = o;
        q.push_back(r);
    endfunction

    function automatic void add_hold(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) add(rb(), rb(), rb(), rop(), rf(), base(st));
    endfunction

    // Expected per-cycle trace of one instruction: di/dd are cycles waited before each grant.
    function automatic void gen(input logic [6:0] op, input logic [2:0] f3, input int di,
                                input int dd, input logic bt, input int hold);
        out_t o;
        logic ld, stq, jal, jalr;
        ld = (op == L_LOAD); stq = (op == L_STORE); jal = (op == L_JAL); jalr = (op == L_JALR);
        for (int i = 0; i < di && i <= TMO; i++) begin
            o = base(3'd0); o.imem_req = 1'b1;
            add(1'b0, rb(), rb(), rop(), rf(), o);
        end
        if (di > TMO) begin
            m_berr = 1'b1; add_hold(3'd6, hold); return;
        end
        o = base(3'd0); o.imem_req = 1'b1; o.ir_we = 1'b1;
        add(1'b1, rb(), rb(), rop(), rf(), o);
        add(rb(), rb(), rb(), op, f3, base(3'd1));
        if (!(op inside {L_LOAD, L_STORE, L_IMM, L_REG, L_LUI, L_AUIPC, L_JAL, L_JALR, L_BR})) begin
            if (op == L_SYS && f3 == 3'b000) begin
                m_halt = 1'b1; add_hold(3'd5, hold);
            end else begin
                m_ill = 1'b1; add_hold(3'd6, hold);
            end
            return;
        end
        o = base(3'd2);
        if (op == L_BR) begin
            o.pc_we = 1'b1; o.pc_src = bt ? 2'd1 : 2'd0;
            add(rb(), rb(), bt, rop(), rf(), o);
            m_ret++;
            return;
        end
        add(rb(), rb(), rb(), rop(), rf(), o);
        if (ld || stq) begin
            for (int i = 0; i < dd && i <= TMO; i++) begin
                o = base(3'd3); o.dmem_req = 1'b1; o.dmem_we = stq;
                add(rb(), 1'b0, rb(), rop(), rf(), o);
            end
            if (dd > TMO) begin
                m_berr = 1'b1; add_hold(3'd6, hold); return;
            end
            o = base(3'd3); o.dmem_req = 1'b1; o.dmem_we = stq; o.pc_we = stq;
            add(rb(), 1'b1, rb(), rop(), rf(), o);
            if (stq) begin
                m_ret++; return;
            end
        end
        o = base(3'd4); o.reg_write = 1'b1; o.pc_we = 1'b1;
        o.wb_sel = ld ? 2'd1 : ((jal || jalr) ? 2'd2 : 2'd0);
        o.pc_src = jal ? 2'd1 : (jalr ? 2'd2 : 2'd0);
        add(rb(), rb(), rb(), rop(), rf(), o);
        m_ret++;
    endfunction

    task automatic drive(input rec_t r);
        imem_gnt = r.ig; dmem_gnt = r.dg; branch_taken = r.bt; opcode = r.op; func3 = r.f3;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; imem_gnt = 1'b0; dmem_gnt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ret = '0; m_halt = 1'b0; m_ill = 1'b0; m_berr = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_gnt = 1'b1; dmem_gnt = 1'b1; opcode = L_STORE;
        repeat (3) begin
            @(negedge clk); #1;
            total++;
            if (obs !== out_t'(0)) begin
                bad++; $display("FAIL reset_hold got=%h want=%h", obs, out_t'(0));
            end
        end
        do_reset();
    endtask

    task automatic test_addi();
        rec_t r;
        gen(L_IMM, rf(), 0, 0, 1'b0, 0);
        gen(L_IMM, rf(), 1, 0, 1'b0, 0);
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL addi got=%h want=%h", obs, r.o); end
            @(negedge clk);
        end
    endtask

    task automatic test_load();
        rec_t r;
        int   req_cyc = 0, busy_cyc = 0;
        gen(L_LOAD, 3'b010, $urandom_range(0, 2), 3, 1'b0, 0);
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL load got=%h want=%h", obs, r.o); end
            if (dmem_req) req_cyc++;
            if (state != 3'd0) busy_cyc++;
            @(negedge clk);
        end
        total++;
        if (req_cyc !== 4) begin bad++; $display("FAIL load_req_cycles got=%0d want=4", req_cyc); end
        total++;
        if (busy_cyc !== 7) begin bad++; $display("FAIL load_latency got=%0d want=7", busy_cyc); end
    endtask

    task automatic test_branch();
        rec_t r;
        gen(L_BR, 3'b000, $urandom_range(0, 2), 0, 1'b1, 0);
        gen(L_BR, 3'b000, $urandom_range(0, 2), 0, 1'b0, 0);
        gen(L_BR, 3'b001, 0, 0, 1'b1, 0);
        gen(L_JAL, rf(), 0, 0, 1'b0, 0);
        gen(L_JALR, 3'b000, 0, 0, 1'b0, 0);
        gen(L_STORE, 3'b010, 0, 1, 1'b0, 0);
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL branch got=%h want=%h", obs, r.o); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        rec_t r;
        gen(7'b0000000, rf(), 0, 0, 1'b0, 20);
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL illegal got=%h want=%h", obs, r.o); end
            @(negedge clk);
        end
        do_reset();
        gen(L_IMM, rf(), 0, 0, 1'b0, 0);
        gen(L_SYS, 3'b001, 1, 0, 1'b0, 4);
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL illegal_sys got=%h want=%h", obs, r.o); end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_ecall();
        rec_t r;
        gen(L_REG, rf(), 0, 0, 1'b0, 0);
        gen(L_SYS, 3'b000, 2, 0, 1'b0, 10);
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL ecall got=%h want=%h", obs, r.o); end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        rec_t r;
        gen(L_IMM, rf(), TMO + 1, 0, 1'b0, 6);
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL imem_timeout got=%h want=%h", obs, r.o); end
            @(negedge clk);
        end
        do_reset();
        gen(L_IMM, rf(), TMO, 0, 1'b0, 0);
        gen(L_STORE, 3'b010, 0, TMO, 1'b0, 0);
        gen(L_LOAD, 3'b010, 0, TMO + 1, 1'b0, 5);
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL grant_edge got=%h want=%h", obs, r.o); end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_reset_in_mem();
        rec_t r;
        logic in_mem = 1'b0;
        gen(L_IMM, rf(), 0, 0, 1'b0, 0);
        gen(L_STORE, 3'b010, 0, 3, 1'b0, 0);
        while (q.size() > 0 && !in_mem) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL pre_abort got=%h want=%h", obs, r.o); end
            in_mem = (r.o.st == 3'd3);
            @(negedge clk);
        end
        dmem_gnt = 1'b1; rst_n = 1'b0;
        #1; total++;
        if (obs !== out_t'(0)) begin bad++; $display("FAIL abort_mem got=%h want=%h", obs, out_t'(0)); end
        do_reset();
        gen(L_IMM, rf(), 0, 0, 1'b0, 0);
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL post_abort got=%h want=%h", obs, r.o); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        rec_t       r;
        logic [6:0] ops[9] = '{L_LOAD, L_STORE, L_IMM, L_REG, L_LUI, L_AUIPC, L_JAL, L_JALR, L_BR};
        for (int n = 0; n < 40; n++) begin
            gen(ops[$urandom_range(0, 8)], rf(), $urandom_range(0, TMO), $urandom_range(0, TMO), rb(), 0);
        end
        while (q.size() > 0) begin
            r = q.pop_front(); drive(r); total++;
            if (obs !== r.o) begin bad++; $display("FAIL random got=%h want=%h", obs, r.o); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_branch();
        test_illegal();
        test_ecall();
        test_timeout();
        test_reset_in_mem();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
